icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
Sequences an instruction-cache line refill after a miss. It issues one AXI4 INCR read burst for the missing line and writes each returned beat into the matching icache data RAM word bank. Near the end of the burst it updates the tag/valid RAM and forwards the critical (requested) word to the fetch stage. It sits between the icache lookup logic, the per-word data RAM banks and the CPU AXI read channel.

Parameters:
LINE_WORDS, 8, 32-bit words per line (power of 2); burst length = LINE_WORDS
OFFSET_W, 5, byte-offset bits = log2(LINE_WORDS*4)
INDEX_W, 7, set index bits (addr[11:5] at defaults)
TAG_W, 20, tag bits = 32-OFFSET_W-INDEX_W
AXI_ID, 4'd0, constant arid

Ports:
clk  in  1  clock
resetn  in  1  async active-low reset
miss_req  in  1  level; held from miss until refill_done
miss_addr  in  32  fetch address of the miss, stable while miss_req=1
busy  out  1  refill in progress (state != IDLE)
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
araddr  out  32  line-aligned address {tag,index,OFFSET_W'b0}
arlen  out  8  LINE_WORDS-1
arsize  out  3  3'b010
arburst  out  2  2'b01 (INCR)
arid  out  4  AXI_ID
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
rdata  in  32  AXI R data
rresp  in  2  AXI R response
rlast  in  1  AXI R last
data_we  out  LINE_WORDS  one-hot word-bank write enable
data_index  out  INDEX_W  set index for data RAM write
data_wdata  out  32  word to write
tag_we  out  1  tag/valid RAM write enable
tag_index  out  INDEX_W  set index for tag write
tag_wdata  out  TAG_W+1  {valid,tag}
crit_valid  out  1  one-cycle pulse: requested word available
crit_data  out  32  requested word
refill_done  out  1  one-cycle pulse: refill complete
bus_err  out  1  sticky: error response or burst-length mismatch seen

Behaviour:
- Reset (resetn=0, async): state=IDLE, beat counter=0, latched address=0, bus_err=0. All outputs 0 except constants arlen/arsize/arburst/arid.
- States: IDLE -> AR -> RD -> TAGW -> DONE -> IDLE.
- IDLE: miss_req=1 at a clock edge latches miss_addr and moves to AR. arvalid=1 from the next cycle.
- AR: arvalid=1 and araddr stable until arready=1. The handshake edge moves to RD and clears the beat counter and the line error flag.
- RD: rready=1. On each rvalid beat:
  - data_we bit[cnt]=1 for that cycle only; data_wdata=rdata; data_index=latched index; cnt increments.
  - If cnt == latched addr[OFFSET_W-1:2]: crit_valid=1 and crit_data=rdata in the same cycle (combinational from rdata).
  - rresp != 2'b00 sets the line error flag and bus_err.
- Burst end: the beat with rlast=1 ends RD and moves to TAGW.
  - rlast on cnt != LINE_WORDS-1 sets the error flag and bus_err.
  - Beats past LINE_WORDS-1 without rlast are accepted with rready=1 but not written (data_we=0), and set the error flag.
- TAGW: tag_we=1 for one cycle; tag_index=latched index; tag_wdata={~line_err, latched tag}. An errored line is written invalid.
- DONE: refill_done=1 for one cycle, then IDLE. miss_req may still be high that cycle; IDLE samples miss_req no earlier than the cycle after DONE, so the earliest new AR is 2 cycles after refill_done.
- Minimum latency: miss_req sampled -> refill_done = 1 (AR) + LINE_WORDS (beats, rvalid continuous) + 2 cycles, arready=1 immediately. Defaults: 11 cycles.
- miss_req dropping mid-refill is ignored; the line completes.
- Only one outstanding burst. arvalid never reasserts before rlast.
- Reset mid-burst aborts immediately. No partial tag write occurs, because tag_we is only in TAGW. Draining the interconnect is the SoC reset's responsibility.
- bus_err clears only on reset.

Test Plan:
- miss_addr=0x1FC0_0A2C, arready=1, 8 back-to-back beats D0..D7 -> araddr=0x1FC0_0A20, arlen=7; data_we=0x01..0x80 in order with data_index=0x51; crit_valid with crit_data=D3; tag_wdata={1,0x1FC00}; refill_done 11 cycles after miss_req sampled.
- arready held low 5 cycles -> arvalid and araddr stable throughout; no rready before the AR handshake; done shifted by 5 cycles.
- rvalid gaps (beat every other cycle) -> data_we pulses only on rvalid cycles; cnt does not advance on gaps; all 8 words correct.
- rresp=2'b10 on beat 4 -> bus_err=1; tag_wdata valid bit=0; refill_done still pulses; a second clean refill writes valid=1 with bus_err still 1.
- rlast on beat 5 -> TAGW entered, tag written invalid, bus_err=1; 6 data_we pulses total.
- resetn low during beat 3 -> all outputs 0 asynchronously, no tag_we; after release a new miss runs a normal refill.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: refills one icache line after a miss with a
// single AXI4 INCR burst, then writes tag/valid and signals done.
module icache_refill_ctrl #(
  parameter int       LINE_WORDS = 8,
  parameter int       OFFSET_W   = 5,
  parameter int       INDEX_W    = 7,
  parameter int       TAG_W      = 20,
  parameter logic [3:0] AXI_ID   = 4'd0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  miss_req,
  input  logic [31:0]           miss_addr,
  output logic                  busy,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [3:0]            arid,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  output logic [LINE_WORDS-1:0] data_we,
  output logic [INDEX_W-1:0]    data_index,
  output logic [31:0]           data_wdata,
  output logic                  tag_we,
  output logic [INDEX_W-1:0]    tag_index,
  output logic [TAG_W:0]        tag_wdata,
  output logic                  crit_valid,
  output logic [31:0]           crit_data,
  output logic                  refill_done,
  output logic                  bus_err
);

  localparam int WIDX_W = $clog2(LINE_WORDS);
  localparam int CNT_W  = WIDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_RD,
    S_TAGW,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [31:2]        addr_q;
  logic [31:2]        addr_nx;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nx;
  logic               line_err_q;
  logic               line_err_nx;
  logic               bus_err_q;
  logic               bus_err_nx;
  logic [WIDX_W-1:0]  word_off;
  logic               in_range;
  logic               at_last;
  logic               hit_crit;
  logic               beat_err;
  logic               unused_addr;

  // byte lanes never matter for a word-granular line fill
  assign unused_addr = ^miss_addr[1:0];

  assign word_off = addr_q[OFFSET_W-1:2];
  // the counter saturates one past the line so excess beats are detectable
  assign in_range = ~cnt_q[WIDX_W];
  assign at_last  = (cnt_q == CNT_W'(LINE_WORDS - 1));
  assign hit_crit = (cnt_q == {1'b0, word_off});
  assign beat_err = (rresp != 2'b00) || !in_range
                  || (rlast && !at_last);

  assign busy       = (state != S_IDLE);
  assign araddr     = {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
  assign arlen      = 8'(LINE_WORDS - 1);
  assign arsize     = 3'b010;
  assign arburst    = 2'b01;
  assign arid       = AXI_ID;
  assign data_index = addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign tag_index  = addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign tag_wdata  = tag_we ? {~line_err_q, addr_q[31:32-TAG_W]}
                             : '0;
  assign bus_err    = bus_err_q;

  // state, latched miss address, beat counter and error flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      line_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state      <= state_nx;
      addr_q     <= addr_nx;
      cnt_q      <= cnt_nx;
      line_err_q <= line_err_nx;
      bus_err_q  <= bus_err_nx;
    end
  end

  // next-state and per-cycle strobes for the refill sequence
  always_comb begin
    state_nx    = state;
    addr_nx     = addr_q;
    cnt_nx      = cnt_q;
    line_err_nx = line_err_q;
    bus_err_nx  = bus_err_q;
    arvalid     = 1'b0;
    rready      = 1'b0;
    data_we     = '0;
    data_wdata  = '0;
    tag_we      = 1'b0;
    crit_valid  = 1'b0;
    crit_data   = '0;
    refill_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (miss_req) begin
          addr_nx  = miss_addr[31:2];
          state_nx = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          cnt_nx      = '0;
          line_err_nx = 1'b0;
          state_nx    = S_RD;
        end
      end
      S_RD: begin
        rready = 1'b1;
        if (rvalid) begin
          data_wdata = rdata;
          if (in_range) begin
            data_we = LINE_WORDS'(1) << cnt_q[WIDX_W-1:0];
            cnt_nx  = cnt_q + 1'b1;
          end
          if (hit_crit) begin
            crit_valid = 1'b1;
            crit_data  = rdata;
          end
          if (beat_err) begin
            line_err_nx = 1'b1;
            bus_err_nx  = 1'b1;
          end
          if (rlast) begin
            state_nx = S_TAGW;
          end
        end
      end
      S_TAGW: begin
        tag_we   = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        refill_done = 1'b1;
        state_nx    = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: random AXI slave plus a timeline model of
// the refill; every cycle's outputs are compared against the model.
module tb_icache_refill_ctrl;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        miss_req = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        busy;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic [7:0]  data_we;
  logic [6:0]  data_index;
  logic [31:0] data_wdata;
  logic        tag_we;
  logic [6:0]  tag_index;
  logic [20:0] tag_wdata;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic        refill_done;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_bus_err;
  logic [31:0] rec_araddr;
  int          rec_done;
  int          rec_we_cnt;
  logic [31:0] rec_crit;
  logic [20:0] rec_tag;

  icache_refill_ctrl dut (
    .clk(clk), .resetn(resetn),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .busy(busy),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp), .rlast(rlast),
    .data_we(data_we), .data_index(data_index),
    .data_wdata(data_wdata),
    .tag_we(tag_we), .tag_index(tag_index),
    .tag_wdata(tag_wdata),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .refill_done(refill_done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string w);
    chk({w, " busy"}, busy, 0);
    chk({w, " arvalid"}, arvalid, 0);
    chk({w, " araddr"}, araddr, 0);
    chk({w, " rready"}, rready, 0);
    chk({w, " data_we"}, data_we, 0);
    chk({w, " data_index"}, data_index, 0);
    chk({w, " data_wdata"}, data_wdata, 0);
    chk({w, " tag_we"}, tag_we, 0);
    chk({w, " tag_index"}, tag_index, 0);
    chk({w, " tag_wdata"}, tag_wdata, 0);
    chk({w, " crit_valid"}, crit_valid, 0);
    chk({w, " crit_data"}, crit_data, 0);
    chk({w, " refill_done"}, refill_done, 0);
    chk({w, " bus_err"}, bus_err, 0);
    chk({w, " arlen"}, arlen, 7);
    chk({w, " arsize"}, arsize, 2);
    chk({w, " arburst"}, arburst, 1);
    chk({w, " arid"}, arid, 0);
  endtask

  // One refill. Cycle 0 raises miss_req; the model derives every
  // expected output from the cycle index and the beats it has sent.
  task automatic run_refill(input logic [31:0] a, input int ar_delay,
                            input int gap_pct, input int nbeats,
                            input int err_beat, input bit drop_early,
                            input bit fixed_data);
    logic [31:0] line;
    logic [6:0]  idx;
    logic [19:0] tag;
    int          off;
    int          hs;
    int          last;
    int          k;
    bit          lerr;
    bit          beat;
    bit          lst;
    bit          fin;
    logic [31:0] d;
    logic [1:0]  rr;
    line = {a[31:5], 5'b0};
    idx  = a[11:5];
    tag  = a[31:12];
    off  = int'(a[4:2]);
    hs = -1; last = -1; k = 0; lerr = 0; fin = 0;
    d = '0; rr = '0; lst = 0;
    rec_we_cnt = 0; rec_done = -1;
    rec_araddr = '0; rec_crit = '0; rec_tag = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      #1;
      arready = 0; rvalid = 0; rlast = 0; rresp = 0;
      rdata = $urandom;
      beat = 0;
      if (cyc == 0) begin
        miss_req = 1; miss_addr = a;
      end
      if (drop_early && cyc == 2) miss_req = 0;
      if (last >= 0 && cyc == last + 3) miss_req = 0;
      if (cyc >= 1 && hs < 0 && cyc >= 1 + ar_delay) begin
        arready = 1; hs = cyc;
      end else if (hs >= 0 && last < 0 && k < nbeats
                   && $urandom_range(99) >= gap_pct) begin
        beat = 1;
        d   = fixed_data ? 32'hD000_0000 + k : $urandom;
        rr  = (k == err_beat) ? 2'b10 : 2'b00;
        lst = (k == nbeats - 1);
        rvalid = 1; rdata = d; rresp = rr; rlast = lst;
        if (lst) last = cyc;
      end
      @(negedge clk);
      chk("busy", busy,
          cyc >= 1 && (last < 0 || cyc <= last + 2));
      chk("arvalid", arvalid, cyc >= 1 && (hs < 0 || cyc <= hs));
      if (cyc >= 1 && (hs < 0 || cyc <= hs))
        chk("araddr", araddr, line);
      chk("rready", rready,
          hs >= 0 && cyc > hs && (last < 0 || cyc <= last));
      chk("data_we", data_we,
          (beat && k < LW) ? (64'd1 << k) : 64'd0);
      if (beat && k < LW) begin
        chk("data_wdata", data_wdata, d);
        chk("data_index", data_index, idx);
      end
      chk("crit_valid", crit_valid, beat && k == off);
      if (beat && k == off) chk("crit_data", crit_data, d);
      chk("tag_we", tag_we, last >= 0 && cyc == last + 1);
      if (last >= 0 && cyc == last + 1) begin
        chk("tag_index", tag_index, idx);
        chk("tag_wdata", tag_wdata, {~lerr, tag});
      end
      chk("refill_done", refill_done,
          last >= 0 && cyc == last + 2);
      chk("bus_err", bus_err, m_bus_err);
      if (cyc == 1) rec_araddr = araddr;
      if (|data_we) rec_we_cnt++;
      if (crit_valid) rec_crit = crit_data;
      if (tag_we) rec_tag = tag_wdata;
      if (refill_done) rec_done = cyc;
      if (beat) begin
        if (rr != 2'b00 || k >= LW || (lst && k != LW - 1)) begin
          lerr = 1; m_bus_err = 1;
        end
        k++;
      end
      if (last >= 0 && cyc == last + 3) begin
        fin = 1;
        break;
      end
    end
    chk("refill finished within budget", fin, 1);
  endtask

  initial begin
    logic [31:0] a;
    int nb;
    int eb;
    m_bus_err = 0;

    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    resetn = 1;

    run_refill(32'h1FC0_0A2C, 0, 0, 8, -1, 0, 1);
    chk("lit araddr", rec_araddr, 32'h1FC0_0A20);
    chk("lit done cycle", rec_done, 11);
    chk("lit crit word", rec_crit, 32'hD000_0003);
    chk("lit tag", rec_tag, {1'b1, 20'h1FC00});
    chk("lit we count", rec_we_cnt, 8);

    run_refill(32'h0000_1234, 5, 0, 8, -1, 0, 1);
    chk("lit done ar stall", rec_done, 16);

    run_refill(32'h8765_4320, 0, 50, 8, -1, 0, 0);
    chk("lit we count gaps", rec_we_cnt, 8);

    run_refill(32'h4000_0F04, 0, 0, 8, 4, 0, 0);
    chk("lit err tag valid", rec_tag[20], 0);
    chk("lit err bus_err", bus_err, 1);
    run_refill(32'h4000_0F44, 1, 20, 8, -1, 1, 0);
    chk("lit clean tag valid", rec_tag[20], 1);
    chk("lit bus_err sticky", bus_err, 1);

    run_refill(32'h2222_2218, 0, 0, 6, -1, 0, 0);
    chk("lit short we count", rec_we_cnt, 6);
    chk("lit short tag valid", rec_tag[20], 0);

    run_refill(32'h3333_3300, 0, 0, 10, -1, 0, 0);
    chk("lit long we count", rec_we_cnt, 8);
    chk("lit long tag valid", rec_tag[20], 0);

    // reset in the middle of beat 3
    @(posedge clk); #1;
    miss_req = 1; miss_addr = 32'h5555_5540;
    @(posedge clk); #1;
    arready = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      arready = 0; rvalid = 1; rdata = $urandom; rresp = 0;
    end
    @(posedge clk); #1;
    rdata = 32'hCAFE_F00D;
    #2;
    resetn = 0;
    #1;
    chk_reset_outputs("mid-burst reset");
    m_bus_err = 0;
    miss_req = 0; rvalid = 0; rlast = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tag_we in reset", tag_we, 0);
    end
    resetn = 1;
    run_refill(32'h5555_5540, 0, 0, 8, -1, 0, 0);
    chk("lit post-reset we count", rec_we_cnt, 8);
    chk("lit post-reset tag valid", rec_tag[20], 1);

    for (int t = 0; t < 30; t++) begin
      a  = $urandom;
      nb = ($urandom_range(3) == 0) ? int'($urandom_range(10, 4)) : 8;
      eb = ($urandom_range(4) == 0) ? int'($urandom_range(nb - 1))
                                    : -1;
      run_refill(a, int'($urandom_range(3)),
                 int'($urandom_range(50)), nb, eb,
                 bit'($urandom_range(1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
